// File: rtl/fft_pkg.sv
// Shared defaults and state encoding for the FFT butterfly scheduler.
package fft_pkg;

   localparam int LOG2N_DEF    = 5;
   localparam int N_DEF        = 1 << LOG2N_DEF;
   localparam int BFLY_LAT_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/fft_bfly_addr.sv
// In-place radix-2 operand addressing: maps (stage, butterfly index) to the
// two operand addresses and the twiddle ROM index.
module fft_bfly_addr
   import fft_pkg::*;
#(
   parameter int LOG2N = LOG2N_DEF
) (
   input  logic [2:0]       stage,
   input  logic [LOG2N-2:0] j,
   output logic [LOG2N-1:0] addr_a,
   output logic [LOG2N-1:0] addr_b,
   output logic [LOG2N-2:0] tw_idx
);

   logic [LOG2N-1:0] j_ext_s;
   logic [LOG2N-1:0] half_s;
   logic [LOG2N-1:0] mask_s;
   logic [LOG2N-1:0] hi_s;
   logic [LOG2N-1:0] lo_s;
   logic [LOG2N-1:0] tw_full_s;
   logic [2:0]       tw_shift_s;

   // Group index goes to the upper bits, offset within the group stays low.
   always_comb begin
      j_ext_s    = {1'b0, j};
      half_s     = LOG2N'(1) << stage;
      mask_s     = half_s - LOG2N'(1);
      hi_s       = (j_ext_s >> stage) << (stage + 3'd1);
      lo_s       = j_ext_s & mask_s;
      addr_a     = hi_s | lo_s;
      addr_b     = addr_a + half_s;
      tw_shift_s = 3'(LOG2N - 1) - stage;
      tw_full_s  = lo_s << tw_shift_s;
      tw_idx     = tw_full_s[LOG2N-2:0];
   end

endmodule

// File: rtl/fft_bfly_sched.sv
// Butterfly issue scheduler for an in-place radix-2 FFT: walks stages and
// butterflies, drains the datapath between stages, and delays issues into write-backs.
module fft_bfly_sched
   import fft_pkg::*;
#(
   parameter int LOG2N    = LOG2N_DEF,
   parameter int BFLY_LAT = BFLY_LAT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             dp_ready,
   output logic             busy,
   output logic             done,
   output logic [2:0]       stage,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_idx,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b
);

   localparam int             JW         = LOG2N - 1;
   localparam int             PW         = BFLY_LAT * LOG2N;
   localparam logic [JW-1:0]  J_LAST     = {JW{1'b1}};
   localparam logic [2:0]     STAGE_LAST = 3'(LOG2N - 1);
   localparam logic [2:0]     DRAIN_LAST = 3'(BFLY_LAT - 1);

   state_e                         state_q, state_d;
   logic [2:0]                     stage_q, stage_d;
   logic [JW-1:0]                  j_q, j_d;
   logic [2:0]                     drain_q, drain_d;
   logic [BFLY_LAT-1:0]            vld_q, vld_d;
   logic [BFLY_LAT-1:0][LOG2N-1:0] pa_q, pa_d;
   logic [BFLY_LAT-1:0][LOG2N-1:0] pb_q, pb_d;

   logic             issue_s;
   logic             flush_s;
   logic             in_issue_s;
   logic [LOG2N-1:0] addr_a_s;
   logic [LOG2N-1:0] addr_b_s;
   logic [LOG2N-2:0] tw_s;
   logic [LOG2N-1:0] iss_a_s;
   logic [LOG2N-1:0] iss_b_s;

   fft_bfly_addr #(
      .LOG2N (LOG2N)
   ) u_addr (
      .stage  (stage_q),
      .j      (j_q),
      .addr_a (addr_a_s),
      .addr_b (addr_b_s),
      .tw_idx (tw_s)
   );

   assign flush_s    = abort && (state_q != ST_IDLE);
   assign in_issue_s = (state_q == ST_ISSUE);

   // Stage/butterfly walk; a cancel outranks every other transition.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      j_d     = j_q;
      drain_d = drain_q;
      issue_s = 1'b0;
      if (flush_s) begin
         state_d = ST_IDLE;
         stage_d = 3'd0;
         j_d     = '0;
         drain_d = 3'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_ISSUE;
                  stage_d = 3'd0;
                  j_d     = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ISSUE: begin
               issue_s = dp_ready;
               if (dp_ready) begin
                  if (j_q == J_LAST) begin
                     j_d     = '0;
                     drain_d = 3'd0;
                     state_d = ST_DRAIN;
                  end else begin
                     j_d = j_q + JW'(1);
                  end
               end else begin
                  j_d = j_q;
               end
            end
            ST_DRAIN: begin
               if (drain_q == DRAIN_LAST) begin
                  drain_d = 3'd0;
                  if (stage_q == STAGE_LAST) begin
                     state_d = ST_DONE;
                  end else begin
                     stage_d = stage_q + 3'd1;
                     state_d = ST_ISSUE;
                  end
               end else begin
                  drain_d = drain_q + 3'd1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               stage_d = 3'd0;
            end
            default: begin
               state_d = ST_IDLE;
               stage_d = 3'd0;
               j_d     = '0;
               drain_d = 3'd0;
            end
         endcase
      end
   end

   // Write-back delay line; idle slots carry zero addresses.
   always_comb begin
      if (issue_s) begin
         iss_a_s = addr_a_s;
         iss_b_s = addr_b_s;
      end else begin
         iss_a_s = {LOG2N{1'b0}};
         iss_b_s = {LOG2N{1'b0}};
      end
      if (flush_s) begin
         vld_d = '0;
         pa_d  = '0;
         pb_d  = '0;
      end else begin
         vld_d = BFLY_LAT'({vld_q, issue_s});
         pa_d  = PW'({pa_q, iss_a_s});
         pb_d  = PW'({pb_q, iss_b_s});
      end
   end

   // State, counters and delay line registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         stage_q <= 3'd0;
         j_q     <= '0;
         drain_q <= 3'd0;
         vld_q   <= '0;
         pa_q    <= '0;
         pb_q    <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         j_q     <= j_d;
         drain_q <= drain_d;
         vld_q   <= vld_d;
         pa_q    <= pa_d;
         pb_q    <= pb_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE) && !abort;
   assign stage     = stage_q;
   assign rd_en     = issue_s;
   assign rd_addr_a = in_issue_s ? addr_a_s : {LOG2N{1'b0}};
   assign rd_addr_b = in_issue_s ? addr_b_s : {LOG2N{1'b0}};
   assign tw_idx    = in_issue_s ? tw_s : {(LOG2N-1){1'b0}};
   assign wr_en     = vld_q[BFLY_LAT-1];
   assign wr_addr_a = pa_q[BFLY_LAT-1];
   assign wr_addr_b = pb_q[BFLY_LAT-1];

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Self-checking bench for fft_bfly_sched: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
module tb_fft_bfly_sched;
   import fft_pkg::*;

   localparam int LOG2N = LOG2N_DEF;
   localparam int N     = N_DEF;
   localparam int HALFN = N / 2;
   localparam int LAT   = BFLY_LAT_DEF;
   localparam int TOTAL = HALFN * LOG2N;

   logic             clk      = 1'b0;
   logic             rst      = 1'b1;
   logic             start    = 1'b0;
   logic             abort    = 1'b0;
   logic             dp_ready = 1'b1;
   logic             busy, done, rd_en, wr_en;
   logic [2:0]       stage;
   logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [LOG2N-2:0] tw_idx;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   fft_bfly_sched #(.LOG2N(LOG2N), .BFLY_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .dp_ready(dp_ready),
      .busy(busy), .done(done), .stage(stage), .rd_en(rd_en),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
      .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_a(input int k, input int j);
      int h = 2 ** k;
      return (j / h) * 2 * h + (j % h);
   endfunction

   function automatic int ref_tw(input int k, input int j);
      int h = 2 ** k;
      return (j % h) * (HALFN / h);
   endfunction

   // Reference model: a run is TOTAL butterflies issued in order; each issue
   // becomes a write LAT cycles later; stages are separated by LAT idle cycles.
   typedef struct {int due; int a; int b;} wr_t;
   wr_t wq[$];
   int  m_phase  = 0;   // 0 idle, 1 issuing, 2 draining, 3 done
   int  m_issued = 0;
   int  m_drain  = 0;
   int  cyc      = 0;

   initial begin : model
      int k, j;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_phase = 0; m_issued = 0; m_drain = 0; wq.delete();
         end else begin
            if (wq.size() > 0 && wq[0].due == cyc) void'(wq.pop_front());
            if (m_phase != 0 && abort) begin
               m_phase = 0; wq.delete();
            end else begin
               case (m_phase)
                  0: if (start) begin m_phase = 1; m_issued = 0; end
                  1: if (dp_ready) begin
                        k = m_issued / HALFN;
                        j = m_issued % HALFN;
                        wq.push_back('{due: cyc + LAT, a: ref_a(k, j), b: ref_a(k, j) + 2 ** k});
                        m_issued++;
                        if (m_issued % HALFN == 0) begin m_phase = 2; m_drain = LAT; end
                     end
                  2: begin
                        m_drain--;
                        if (m_drain == 0) m_phase = (m_issued == TOTAL) ? 3 : 1;
                     end
                  default: m_phase = 0;
               endcase
            end
            cyc++;
         end
      end
   end

   initial begin : mon
      int k, jj, ea, eb, et, ewa, ewb;
      bit ewr;
      forever begin
         @(negedge clk);
         if (chk_on) begin
            if (m_phase == 1) k = m_issued / HALFN;
            else if (m_phase == 0) k = 0;
            else k = (m_issued - 1) / HALFN;
            jj = m_issued % HALFN;
            ea = (m_phase == 1) ? ref_a(k, jj) : 0;
            eb = (m_phase == 1) ? ref_a(k, jj) + 2 ** k : 0;
            et = (m_phase == 1) ? ref_tw(k, jj) : 0;
            ewr = (wq.size() > 0 && wq[0].due == cyc);
            ewa = ewr ? wq[0].a : 0;
            ewb = ewr ? wq[0].b : 0;
            check_eq("busy",  busy,  m_phase != 0);
            check_eq("done",  done,  (m_phase == 3) && !abort);
            check_eq("stage", stage, k);
            check_eq("rd_en", rd_en, (m_phase == 1) && dp_ready && !abort);
            check_eq("rd_a",  rd_addr_a, ea);
            check_eq("rd_b",  rd_addr_b, eb);
            check_eq("tw",    tw_idx, et);
            check_eq("wr_en", wr_en, ewr);
            check_eq("wr_a",  wr_addr_a, ewa);
            check_eq("wr_b",  wr_addr_b, ewb);
         end
      end
   end

   int o_rd[256], o_wr[256], o_busy[256], o_a[256], o_b[256], o_tw[256];
   int rd_cnt, wr_cnt, done_cnt, done_rel, busy_first, busy_last, busy_cnt;

   // Drives one scenario; cycle 0 is the cycle the first start is presented in.
   task automatic run_watch(input int budget, input int s0, input int s1, input int s2,
                            input int s3, input int ab_at, input int st_at, input int st_len);
      rd_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_cnt = 0;
      done_rel = -1; busy_first = -1; busy_last = -1;
      for (int rel = 0; rel < budget; rel++) begin
         @(posedge clk); #1;
         start    = (rel == s0) || (rel == s1) || (rel == s2) || (rel == s3);
         abort    = (rel == ab_at);
         dp_ready = !(rel >= st_at && rel < st_at + st_len);
         @(negedge clk);
         o_rd[rel] = int'(rd_en); o_wr[rel] = int'(wr_en); o_busy[rel] = int'(busy);
         o_a[rel] = int'(rd_addr_a); o_b[rel] = int'(rd_addr_b); o_tw[rel] = int'(tw_idx);
         if (rd_en) rd_cnt++;
         if (wr_en) wr_cnt++;
         if (done) begin
            done_cnt++;
            if (done_rel < 0) done_rel = rel;
         end
         if (busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = rel;
            busy_last = rel;
         end
      end
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; dp_ready = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_rd_en", rd_en, 1'b0);
      check_eq("rst_wr_en", wr_en, 1'b0);
      check_eq("rst_rd_b", rd_addr_b, 0);
      check_eq("rst_stage", stage, 0);
      rst = 1'b0;
      chk_on = 1'b1;

      // Uninterrupted run with the datapath always ready.
      run_watch(110, 0, -1, -1, -1, -1, -1, 0);
      check_eq("full_rd_cnt", rd_cnt, 80);
      check_eq("full_wr_cnt", wr_cnt, 80);
      check_eq("full_done_cyc", done_rel, 96);
      check_eq("full_done_cnt", done_cnt, 1);
      check_eq("full_busy_first", busy_first, 1);
      check_eq("full_busy_last", busy_last, 96);
      check_eq("full_busy_cnt", busy_cnt, 96);
      check_eq("s2j5_a", o_a[44], 9);
      check_eq("s2j5_b", o_b[44], 13);
      check_eq("s2j5_tw", o_tw[44], 4);
      check_eq("s4j15_a", o_a[92], 15);
      check_eq("s4j15_b", o_b[92], 31);
      check_eq("s4j15_tw", o_tw[92], 15);
      check_eq("drain_no_rd", o_rd[17], 0);

      // Four-cycle stall at stage 1, butterfly 7.
      run_watch(115, 0, -1, -1, -1, -1, 27, 4);
      check_eq("stall_a_first", o_a[27], 13);
      check_eq("stall_b_first", o_b[27], 15);
      check_eq("stall_tw_first", o_tw[27], 8);
      check_eq("stall_a_last", o_a[30], 13);
      check_eq("stall_b_last", o_b[30], 15);
      check_eq("stall_rd_low", o_rd[28], 0);
      check_eq("stall_resume_rd", o_rd[31], 1);
      check_eq("stall_resume_a", o_a[31], 13);
      check_eq("stall_next_a", o_a[32], 16);
      check_eq("stall_rd_cnt", rd_cnt, 80);
      check_eq("stall_done_cyc", done_rel, 100);

      // Cancel during the stage-3 drain.
      run_watch(120, 0, -1, -1, -1, 75, -1, 0);
      check_eq("abort_wr_before", o_wr[75], 1);
      check_eq("abort_wr_after", o_wr[76], 0);
      check_eq("abort_busy_after", o_busy[76], 0);
      check_eq("abort_done_cnt", done_cnt, 0);
      run_watch(110, 0, -1, -1, -1, -1, -1, 0);
      check_eq("post_abort_done_cyc", done_rel, 96);
      check_eq("post_abort_done_cnt", done_cnt, 1);

      // Extra starts while busy, including in the completion cycle.
      run_watch(130, 0, 10, 50, 96, -1, -1, 0);
      check_eq("restart_done_cnt", done_cnt, 1);
      check_eq("restart_done_cyc", done_rel, 96);
      check_eq("restart_idle_after", o_busy[97], 0);
      check_eq("restart_rd_cnt", rd_cnt, 80);

      // Asynchronous reset while issuing.
      run_watch(30, 0, -1, -1, -1, -1, -1, 0);
      check_eq("pre_rst_wr_en", wr_en, 1'b1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check_eq("arst_busy", busy, 1'b0);
      check_eq("arst_done", done, 1'b0);
      check_eq("arst_rd_en", rd_en, 1'b0);
      check_eq("arst_wr_en", wr_en, 1'b0);
      check_eq("arst_rd_a", rd_addr_a, 0);
      check_eq("arst_rd_b", rd_addr_b, 0);
      check_eq("arst_tw", tw_idx, 0);
      check_eq("arst_wr_a", wr_addr_a, 0);
      check_eq("arst_wr_b", wr_addr_b, 0);
      check_eq("arst_stage", stage, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_watch(20, -1, -1, -1, -1, -1, -1, 0);
      check_eq("post_rst_busy_cnt", busy_cnt, 0);
      check_eq("post_rst_wr_cnt", wr_cnt, 0);

      // Random back-pressure, stray starts and occasional cancels.
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            start    = (c == 0) || ($urandom_range(0, 59) == 0);
            abort    = (r % 2 == 1) && ($urandom_range(0, 149) == 0);
            dp_ready = ($urandom_range(0, 3) != 0);
         end
      end
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; dp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
